// File: rtl/bar_pkg.sv
// Shared types for the bar data/valid/ready stream.
// Word width, word type and sink state encoding.
package bar_pkg;
    localparam int BAR_DATA_W = 32;
    typedef logic [BAR_DATA_W-1:0] bar_word_t;
    typedef enum logic {ST_RUN, ST_FLUSH} sink_state_t;
endpackage

// File: rtl/bar_fifo_mem.sv
// FIFO storage for bar_stream_sink: DEPTH words,
// one synchronous write port, one asynchronous read port.
module bar_fifo_mem
    import bar_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  bar_word_t     wdata,
    input  logic [AW-1:0] raddr,
    output bar_word_t     rdata
);

    bar_word_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bar_stream_sink.sv
// Receiving end of the bar stream: FWFT FIFO with flush and backpressure.
// Optional BAR_STREAM_SINK_STATS_EN adds push count and data XOR outputs.
module bar_stream_sink
    import bar_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  bar_word_t        in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output bar_word_t        out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] level
`ifdef BAR_STREAM_SINK_STATS_EN
    ,
    output logic [31:0]      stat_words,
    output logic [31:0]      stat_xor
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    sink_state_t      state;
    sink_state_t      state_nx;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    bar_word_t        head;

    // Readys/valids are gated by rst_n so nothing handshakes in reset.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ST_RUN: begin
                in_ready  = rst_n && (count < CNT_W'(DEPTH));
                out_valid = rst_n && (count != '0);
                if (flush) state_nx = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (!flush) state_nx = ST_RUN;
            end
        endcase
    end

    // A flush on the entry cycle overrides any concurrent handshake.
    assign push     = in_valid && in_ready && !flush;
    assign pop      = out_valid && out_ready && !flush;
    assign out_data = out_valid ? head : '0;
    assign level    = count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nx;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                unique case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    bar_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

`ifdef BAR_STREAM_SINK_STATS_EN
    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_words <= '0;
            stat_xor   <= '0;
        end else if (push) begin
            stat_words <= stat_words + 1'b1;
            stat_xor   <= stat_xor ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_bar_stream_sink.sv
// Self-checking bench for bar_stream_sink: directed table,
// streaming sequence and randomized traffic against a queue model.
module tb_bar_stream_sink;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic        rn;
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        ir;
        logic        ov;
        logic [31:0] od;
        logic [2:0]  lvl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;
`ifdef BAR_STREAM_SINK_STATS_EN
    logic [31:0] stat_words;
    logic [31:0] stat_xor;
`endif

    logic [31:0] q [$];
    bit          m_flushing;
    logic [31:0] m_sw;
    logic [31:0] m_sx;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    bar_stream_sink #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
`ifdef BAR_STREAM_SINK_STATS_EN
        ,
        .stat_words(stat_words),
        .stat_xor  (stat_xor)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit rn, input bit fl, input bit iv,
                                input int d, input bit ordy, input bit ir,
                                input bit ov, input int od, input int lvl);
        vec_t v;
        v.rn = rn; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ir = ir; v.ov = ov; v.od = od; v.lvl = 3'(lvl);
        return v;
    endfunction

    // One clock cycle: drive, check (table and model), advance model.
    task automatic cyc(input vec_t v, input bit use_tab);
        bit          e_ir;
        bit          e_ov;
        logic [31:0] e_od;
        rst_n = v.rn; flush = v.fl; in_valid = v.iv;
        in_data = v.d; out_ready = v.ordy;
        #2;
        if (use_tab) begin
            chk("tab_in_ready", 32'(in_ready), 32'(v.ir));
            chk("tab_out_valid", 32'(out_valid), 32'(v.ov));
            chk("tab_out_data", out_data, v.od);
            chk("tab_level", 32'(level), 32'(v.lvl));
        end
        e_ir = v.rn && !m_flushing && q.size() < DEPTH;
        e_ov = v.rn && !m_flushing && q.size() > 0;
        e_od = e_ov ? q[0] : 32'd0;
        chk("mdl_in_ready", 32'(in_ready), 32'(e_ir));
        chk("mdl_out_valid", 32'(out_valid), 32'(e_ov));
        chk("mdl_out_data", out_data, e_od);
        chk("mdl_level", 32'(level), 32'(q.size()));
`ifdef BAR_STREAM_SINK_STATS_EN
        chk("mdl_stat_words", stat_words, m_sw);
        chk("mdl_stat_xor", stat_xor, m_sx);
`endif
        if (!v.rn) begin
            q.delete();
            m_flushing = 0;
            m_sw = 0;
            m_sx = 0;
        end else if (v.fl) begin
            q.delete();
            m_flushing = 1;
        end else begin
            if (e_ov && v.ordy) void'(q.pop_front());
            if (e_ir && v.iv) begin
                q.push_back(v.d);
                m_sw = m_sw + 1;
                m_sx = m_sx ^ v.d;
            end
            m_flushing = 0;
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tab [29];

    initial begin
        // rn fl iv d ordy | ir ov od lvl
        tab[0]  = mk(0, 0, 0, 0,    0, 0, 0, 0,    0);
        tab[1]  = mk(1, 0, 1, 42,   0, 1, 0, 0,    0);
        tab[2]  = mk(1, 0, 0, 0,    1, 1, 1, 42,   1);
        tab[3]  = mk(1, 0, 0, 0,    0, 1, 0, 0,    0);
        tab[4]  = mk(1, 0, 1, 9001, 0, 1, 0, 0,    0);
        tab[5]  = mk(1, 0, 1, 1337, 0, 1, 1, 9001, 1);
        tab[6]  = mk(1, 0, 1, 1,    0, 1, 1, 9001, 2);
        tab[7]  = mk(1, 0, 1, 2,    0, 1, 1, 9001, 3);
        tab[8]  = mk(1, 0, 1, 5,    0, 0, 1, 9001, 4);
        tab[9]  = mk(1, 0, 1, 7,    1, 0, 1, 9001, 4);
        tab[10] = mk(1, 0, 1, 7,    0, 1, 1, 1337, 3);
        tab[11] = mk(1, 0, 0, 0,    1, 0, 1, 1337, 4);
        tab[12] = mk(1, 0, 0, 0,    1, 1, 1, 1,    3);
        tab[13] = mk(1, 0, 0, 0,    1, 1, 1, 2,    2);
        tab[14] = mk(1, 0, 0, 0,    1, 1, 1, 7,    1);
        tab[15] = mk(1, 0, 0, 0,    0, 1, 0, 0,    0);
        tab[16] = mk(1, 0, 1, 10,   0, 1, 0, 0,    0);
        tab[17] = mk(1, 0, 1, 11,   0, 1, 1, 10,   1);
        tab[18] = mk(1, 0, 1, 12,   0, 1, 1, 10,   2);
        tab[19] = mk(1, 1, 1, 13,   1, 1, 1, 10,   3);
        tab[20] = mk(1, 0, 1, 14,   1, 0, 0, 0,    0);
        tab[21] = mk(1, 0, 1, 14,   0, 1, 0, 0,    0);
        tab[22] = mk(1, 1, 0, 0,    0, 1, 1, 14,   1);
        tab[23] = mk(1, 1, 0, 0,    0, 0, 0, 0,    0);
        tab[24] = mk(1, 0, 1, 15,   0, 0, 0, 0,    0);
        tab[25] = mk(1, 0, 1, 15,   0, 1, 0, 0,    0);
        tab[26] = mk(1, 0, 1, 16,   0, 1, 1, 15,   1);
        tab[27] = mk(0, 0, 1, 17,   1, 0, 0, 0,    2);
        tab[28] = mk(1, 0, 0, 0,    0, 1, 0, 0,    0);

        rst_n = 0; flush = 0; in_valid = 0; in_data = 0; out_ready = 0;
        q.delete(); m_flushing = 0; m_sw = 0; m_sx = 0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 29; i++) cyc(tab[i], 1'b1);

        // Back-to-back streaming: one word per cycle, level held at 1.
        for (int i = 0; i <= 16; i++) begin
            cyc(mk(1, 0, i < 16, i, 1, 1, i > 0,
                   (i > 0) ? i - 1 : 0, (i > 0) ? 1 : 0), 1'b1);
        end

`ifdef BAR_STREAM_SINK_STATS_EN
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        cyc(mk(1, 0, 1, 42,   0, 0, 0, 0, 0), 1'b0);
        cyc(mk(1, 0, 1, 9001, 0, 0, 0, 0, 0), 1'b0);
        cyc(mk(1, 0, 1, 1337, 0, 0, 0, 0, 0), 1'b0);
        #1;
        chk("stats_words", stat_words, 32'd3);
        chk("stats_xor", stat_xor, 32'd42 ^ 32'd9001 ^ 32'd1337);
        cyc(mk(1, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        #1;
        chk("stats_words_flush", stat_words, 32'd3);
        chk("stats_xor_flush", stat_xor, 32'd42 ^ 32'd9001 ^ 32'd1337);
`endif

        // Randomized traffic with phases of differing consumer rate.
        for (int k = 0; k < 3000; k++) begin
            int  ph;
            bit  rn;
            bit  fl;
            bit  iv;
            bit  ordy;
            ph   = (k / 250) % 3;
            rn   = $urandom_range(0, 199) != 0;
            fl   = $urandom_range(0, 39) == 0;
            iv   = $urandom_range(0, 3) != 0;
            ordy = (ph == 0) ? ($urandom_range(0, 3) == 0) :
                   (ph == 1) ? ($urandom_range(0, 1) == 0) :
                               ($urandom_range(0, 3) != 0);
            cyc(mk(rn, fl, iv, int'($urandom), ordy, 0, 0, 0, 0), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bar_stream_sink.md
Name: bar_stream_sink

Overview:
- Receiving end of the `bar` data/valid/ready interface: consumes 32-bit words pushed by a producer module.
- Buffers accepted words in a small first-word-fall-through FIFO and re-presents them on a local pop port.
- Sits between any module driving `bar` signals (data, valid) and downstream logic that cannot always accept immediately.
- Provides backpressure on `bar.ready`.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the fill-level output; derived, not to be overridden.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising clk.
- in_data  input  32  `bar.data` from the producer.
- in_valid  input  1  `bar.valid` from the producer.
- in_ready  output  1  `bar.ready` to the producer.
- flush  input  1  discards all buffered words.
- out_data  output  32  head-of-FIFO word.
- out_valid  output  1  head word is present.
- out_ready  input  1  consumer pops the head word.
- level  output  CNT_W  current number of buffered words.

Behaviour:
- Reset (rst_n=0 at an edge): rd_ptr, wr_ptr and count go to 0; state goes to RUN.
  - Outputs during and after reset: in_ready=0 while rst_n=0; out_valid=0; level=0; out_data=0.
  - Memory contents are not reset, but out_data is masked to 0 whenever out_valid=0.
  - Reset mid-transfer drops all buffered words. No handshake completes on a cycle where rst_n=0.
- State machine, states RUN and FLUSH:
  - RUN -> FLUSH when flush=1.
  - FLUSH clears pointers and count on entry and lasts exactly one cycle, then returns to RUN.
  - If flush is held high, the block stays in FLUSH.
  - In FLUSH: in_ready=0 and out_valid=0.
- Push: occurs when in_valid && in_ready. in_ready = (state==RUN) && (count<DEPTH). in_ready is combinational from registered state only; it never depends on in_valid.
- Pop: occurs when out_valid && out_ready. out_valid = (state==RUN) && (count!=0).
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N. Minimum one-cycle push-to-pop latency. There is no combinational bypass from in_data to out_data.
- Simultaneous push and pop: count unchanged, both pointers advance. Legal at any count 1..DEPTH-1.
- Full (count==DEPTH): in_ready=0. A pop in that cycle raises in_ready on the next cycle, not the same cycle.
- Empty: out_valid=0. out_ready is ignored.
- Pointers are log2(DEPTH) bits and wrap naturally. level equals count.
- Producer protocol: the producer must hold in_data stable while in_valid=1 and in_ready=0. The sink does not check this.
- flush with a simultaneous push or pop: flush wins. Neither handshake takes effect, because both readys/valids are already low in FLUSH. The flush-entry cycle in RUN drops any concurrent push/pop as well.

Optional Feature:
- Macro BAR_STREAM_SINK_STATS_EN.
- Defined: two extra outputs.
  - stat_words (32 bit): counts accepted pushes and wraps at 2^32.
  - stat_xor (32 bit): XOR of every accepted in_data.
  - Both reset to 0 on rst_n=0. Neither is cleared by flush.
- Not defined: the ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package bar_pkg holds:
  - localparam BAR_DATA_W=32;
  - typedef logic [BAR_DATA_W-1:0] bar_word_t;
  - typedef enum logic {ST_RUN, ST_FLUSH} sink_state_t.
- One sub-module, bar_fifo_mem: DEPTH x bar_word_t register array with one write port and one asynchronous read port.
- Pointer, count and FSM logic stay in bar_stream_sink.

Test Plan:
- Single word: after reset, push 42 with out_ready=0 → in_ready=1 at push. Next cycle: out_valid=1, out_data=42, level=1. Pop → level=0, out_valid=0.
- Fill to full: push 9001, 1337, 1, 2 with out_ready=0 → level=4, in_ready=0. A further in_valid=1 with 5 is not accepted. Pop order is 9001, 1337, 1, 2.
- Full plus pop: at level=4, push 7 while popping → 7 is rejected (in_ready=0). Next cycle in_ready=1 and the push of 7 is accepted. Final drain order ends with 7.
- Streaming: in_valid=1 and out_ready=1 continuously with data 0..15 → after first output, one word per cycle; level stays at 1; output sequence 0..15 with no gaps.
- Flush/reset: level=3 then flush=1 for one cycle → next cycle level=0, out_valid=0, in_ready=0. The following cycle in_ready=1. Repeat with rst_n=0 mid-stream → all outputs 0 at the next edge.
- Stats (BAR_STREAM_SINK_STATS_EN): push 42, 9001, 1337 → stat_words=3, stat_xor=42^9001^1337. Then flush → values unchanged.
